// File: rtl/led_pattern_ctrl.sv
// LED pattern controller.
// Two push buttons are synchronized and debounced. The mode button steps
// through four LED patterns and the speed button steps through four step rates.
// The LED pattern advances one step per prescaler tick.
module led_pattern_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4000,
   parameter int BASE_DIV        = 65536
) (
   input  logic       PCLK,
   input  logic       RST,
   input  logic [1:0] BTN,
   output logic [3:0] LD,
   output logic [1:0] MODE,
   output logic [1:0] SPEED
);

   localparam int CW = $clog2(BASE_DIV);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      MODE_COUNT  = 2'b00,
      MODE_SHIFT  = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_BLINK  = 2'b11
   } mode_t;

   // Starting pattern that each mode shows when it is entered or reloaded.
   function automatic logic [3:0] init_pattern(input mode_t m);
      case (m)
         MODE_COUNT:  init_pattern = 4'b0000;
         MODE_SHIFT:  init_pattern = 4'b0001;
         MODE_BOUNCE: init_pattern = 4'b0001;
         default:     init_pattern = 4'b1111;
      endcase
   endfunction

   logic [1:0]    sync_a;
   logic [1:0]    sync_b;
   logic [1:0]    db_level;
   logic [DW-1:0] db_cnt [2];
   logic [1:0]    press;

   mode_t         mode_q, mode_d;
   logic [1:0]    speed_q, speed_d;
   logic [3:0]    ld_q, ld_d;
   logic          dir_up_q, dir_up_d;
   logic [CW-1:0] pre_q, pre_d;
   logic [CW-1:0] pre_last;
   logic          tick;

   // Two-flop synchronizer, because the buttons are asynchronous to PCLK.
   always_ff @(posedge PCLK) begin
      if (RST) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= BTN;
         sync_b <= sync_a;
      end
   end

   // Debounce each button. A new level is accepted only after it has differed
   // from the held level for DEBOUNCE_CYCLES samples in a row. The press pulse
   // is raised on the same edge a rising level is accepted, so the press takes
   // effect on the following edge.
   always_ff @(posedge PCLK) begin
      if (RST) begin
         db_level <= '0;
         press    <= '0;
         for (int i = 0; i < 2; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            press[i] <= 1'b0;
            if (sync_b[i] == db_level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_cnt[i]   <= '0;
               db_level[i] <= sync_b[i];
               press[i]    <= sync_b[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // The step period halves with each speed index. BASE_DIV is a power of two,
   // so (BASE_DIV-1) >> SPEED is the same as (BASE_DIV >> SPEED) - 1.
   assign pre_last = CW'((BASE_DIV - 1) >> speed_q);
   assign tick     = (pre_q == pre_last);

   // Register the pattern state, mode, speed and prescaler.
   always_ff @(posedge PCLK) begin
      if (RST) begin
         mode_q   <= MODE_COUNT;
         speed_q  <= 2'd0;
         ld_q     <= 4'b0000;
         dir_up_q <= 1'b1;
         pre_q    <= '0;
      end else begin
         mode_q   <= mode_d;
         speed_q  <= speed_d;
         ld_q     <= ld_d;
         dir_up_q <= dir_up_d;
         pre_q    <= pre_d;
      end
   end

   // Next-state logic. Button presses take precedence, so a tick that lands
   // on the same cycle as a press is dropped.
   always_comb begin
      mode_d   = mode_q;
      speed_d  = speed_q;
      ld_d     = ld_q;
      dir_up_d = dir_up_q;
      pre_d    = tick ? '0 : pre_q + 1'b1;

      if (press[0] && press[1]) begin
         ld_d     = init_pattern(mode_q);
         dir_up_d = 1'b1;
         pre_d    = '0;
      end else if (press[0]) begin
         mode_d   = mode_t'(mode_q + 2'd1);
         ld_d     = init_pattern(mode_d);
         dir_up_d = 1'b1;
         pre_d    = '0;
      end else if (press[1]) begin
         speed_d = speed_q + 2'd1;
         pre_d   = '0;
      end else if (tick) begin
         case (mode_q)
            MODE_COUNT: begin
               ld_d = ld_q + 4'd1;
            end
            MODE_SHIFT: begin
               ld_d = {ld_q[2:0], ld_q[3]};
            end
            MODE_BOUNCE: begin
               if (dir_up_q) begin
                  ld_d = {ld_q[2:0], 1'b0};
                  if (ld_d == 4'b1000) begin
                     dir_up_d = 1'b0;
                  end
               end else begin
                  ld_d = {1'b0, ld_q[3:1]};
                  if (ld_d == 4'b0001) begin
                     dir_up_d = 1'b1;
                  end
               end
            end
            default: begin
               ld_d = ~ld_q;
            end
         endcase
      end
   end

   assign LD    = ld_q;
   assign MODE  = mode_q;
   assign SPEED = speed_q;

endmodule
